icache_axi_rd_bridge: RTL and testbench

- AXI4 read master that services the instruction cache's miss/uncached refill request port (rd_req/rd_rdy/rd_addr/rd_uncache -> ret_valid/ret_data).
- Cached requests become one 4-beat INCR line burst; uncached requests become a single-beat read.
- Sits between icache and the AXI crossbar.
- One outstanding transaction; the returned line is delivered to the cache in a single ret_valid cycle.

---
 rtl/icache_axi_rd_bridge.sv | 144 ++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// ---------------------------------------------------------------------------
// icache_axi_rd_bridge
//
// AXI4 read master that serves the instruction cache refill port. A cached
// miss becomes one 4-beat INCR burst of 32-bit words. An uncached fetch
// becomes a single-beat read. Only one transaction is in flight at a time.
// The whole line goes back to the cache in a single ret_valid cycle.
//
// Ports
//   clk_g, resetn        clock, synchronous active-low reset
//   rd_req/rd_rdy        icache request handshake (rd_rdy high only in IDLE)
//   rd_addr, rd_uncache  request address and uncached flag
//   ret_valid/ret_data   one-cycle line return (word i at [32i+31:32i]);
//                        an uncached word is returned at [127:96]
//   ret_err              qualifies ret_valid: bad rresp or wrong beat count
//   ar*                  AXI read address channel (master side)
//   r*                   AXI read data channel (master side); rid is unused
// ---------------------------------------------------------------------------
module icache_axi_rd_bridge #(
  parameter logic [3:0] ARID          = 4'd0,
  parameter int         LINE_WORD_NUM = 4
) (
  input  logic         clk_g,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  input  logic         rd_uncache,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

  localparam logic [2:0] LINE_WORDS = 3'(LINE_WORD_NUM);
  localparam logic [2:0] LAST_IDX   = 3'(LINE_WORD_NUM - 1);

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic           unc_q, unc_d;
  logic [127:0]   buf_q, buf_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           err_q, err_d;

  // Only one outstanding read exists, so the returned ID carries no information.
  logic unused_rid;
  assign unused_rid = ^rid;

  always_ff @(posedge clk_g) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= '0;
      unc_q   <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      unc_q   <= unc_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unc_d   = unc_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          addr_d  = rd_addr;
          unc_d   = rd_uncache;
          buf_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = AR;
        end
      end
      AR: begin
        if (arready) state_d = R;
      end
      R: begin
        if (rvalid) begin
          if (unc_q) begin
            // Extra beats on an uncached read overwrite the word and are flagged.
            buf_d[127:96] = rdata;
            if (!rlast) err_d = 1'b1;
          end else if (cnt_q < LINE_WORDS) begin
            buf_d[{cnt_q[1:0], 5'd0} +: 32] = rdata;
            cnt_d = cnt_q + 3'd1;
            // rlast before the final word leaves the remaining words zero.
            if (rlast && (cnt_q != LAST_IDX)) err_d = 1'b1;
          end else begin
            // Beats beyond the line are dropped; the burst was malformed.
            err_d = 1'b1;
          end
          if (rresp != 2'b00) err_d = 1'b1;
          if (rlast) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The AR fields derive only from registers latched at acceptance, so they
  // stay stable for as long as arready is withheld.
  assign rd_rdy    = (state_q == IDLE);
  assign arvalid   = (state_q == AR);
  assign rready    = (state_q == R);
  assign ret_valid = (state_q == DONE);
  assign ret_err   = ret_valid & err_q;
  assign ret_data  = buf_q;
  assign arid      = ARID;
  assign araddr    = unc_q ? addr_q : {addr_q[31:4], 4'b0000};
  assign arlen     = unc_q ? 8'd0 : 8'(LINE_WORD_NUM - 1);
  assign arsize    = 3'b010;
  assign arburst   = 2'b01;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed table-driven bench for icache_axi_rd_bridge. The bench plays the
// AXI slave cycle by cycle: inputs change and outputs are sampled on the
// falling edge, and the DUT acts on the rising edge.
module tb_icache_axi_rd_bridge;

  logic         clk_g = 1'b0;
  logic         resetn;
  logic         rd_req;
  logic [31:0]  rd_addr;
  logic         rd_uncache;
  logic         rd_rdy;
  logic         ret_valid;
  logic [127:0] ret_data;
  logic         ret_err;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  int nTests = 0;
  int nFail  = 0;

  icache_axi_rd_bridge dut (
    .clk_g(clk_g), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_uncache(rd_uncache), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready)
  );

  always #5 clk_g = ~clk_g;

  // One read transaction: request, slave behaviour and expected results.
  typedef struct packed {
    logic [31:0]       addr;
    logic              unc;
    int                ar_stall;
    int                r_gap;
    int                nbeats;
    logic [4:0][31:0]  data;
    logic [4:0][1:0]   resp;
    logic [31:0]       exp_araddr;
    logic [7:0]        exp_arlen;
    logic [127:0]      exp_data;
    logic              exp_err;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(logic [31:0] addr, logic unc, int stall, int gap, int nb,
                              logic [4:0][31:0] d, logic [4:0][1:0] r, logic [31:0] ea,
                              logic [7:0] el, logic [127:0] ed, logic ee);
    vec_t v;
    v.addr = addr; v.unc = unc; v.ar_stall = stall; v.r_gap = gap; v.nbeats = nb;
    v.data = d; v.resp = r; v.exp_araddr = ea; v.exp_arlen = el;
    v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    nTests++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present a request in IDLE; with hold set, rd_req stays asserted afterwards.
  task automatic issue(input logic [31:0] addr, input logic unc, input logic hold);
    rd_req = 1'b1;
    rd_addr = addr;
    rd_uncache = unc;
    checkOutput("rd_rdy_idle", rd_rdy, 1);
    @(negedge clk_g);
    if (!hold) rd_req = 1'b0;
  endtask

  // Slave side from the AR phase through the cycle after the line return.
  task automatic serve(input vec_t v);
    for (int s = 0; s < v.ar_stall; s++) begin
      arready = 1'b0;
      checkOutput("arvalid_stall", arvalid, 1);
      checkOutput("araddr_stall", araddr, v.exp_araddr);
      checkOutput("arlen_stall", arlen, v.exp_arlen);
      checkOutput("rd_rdy_busy", rd_rdy, 0);
      @(negedge clk_g);
    end
    arready = 1'b1;
    checkOutput("arvalid", arvalid, 1);
    checkOutput("araddr", araddr, v.exp_araddr);
    checkOutput("arlen", arlen, v.exp_arlen);
    checkOutput("arsize_arburst_arid", {arsize, arburst, arid}, {3'b010, 2'b01, 4'd0});
    @(negedge clk_g);
    arready = 1'b0;
    checkOutput("arvalid_drop", arvalid, 0);
    for (int i = 0; i < v.nbeats; i++) begin
      for (int g = 0; g < v.r_gap; g++) begin
        rvalid = 1'b0;
        checkOutput("rready_gap", rready, 1);
        checkOutput("ret_valid_early", ret_valid, 0);
        checkOutput("rd_rdy_busy", rd_rdy, 0);
        @(negedge clk_g);
      end
      rvalid = 1'b1;
      rdata = v.data[i];
      rresp = v.resp[i];
      rlast = (i == v.nbeats - 1);
      checkOutput("rready", rready, 1);
      @(negedge clk_g);
      rvalid = 1'b0;
      rlast = 1'b0;
      rresp = 2'b00;
    end
    checkOutput("ret_valid", ret_valid, 1);
    checkOutput("ret_err", ret_err, v.exp_err);
    checkOutput("ret_data", ret_data, v.exp_data);
    checkOutput("rd_rdy_done", rd_rdy, 0);
    @(negedge clk_g);
    checkOutput("ret_valid_pulse", ret_valid, 0);
    checkOutput("rd_rdy_after", rd_rdy, 1);
    checkOutput("ret_data_hold", ret_data, v.exp_data);
    checkOutput("rready_after", rready, 0);
  endtask

  task automatic applyStimulus(input vec_t v);
    issue(v.addr, v.unc, 1'b0);
    serve(v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vb;
    resetn = 1'b0; rd_req = 1'b0; rd_addr = '0; rd_uncache = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

    vecs[0] = mk(32'h1FC0_0124, 0, 0, 0, 4, {32'h0, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, '0,
                 32'h1FC0_0120, 8'd3, 128'h000000A3_000000A2_000000A1_000000A0, 0);
    vecs[1] = mk(32'hBFC0_0008, 1, 0, 0, 1, {128'h0, 32'h3C08BFC0}, '0,
                 32'hBFC0_0008, 8'd0, {32'h3C08BFC0, 96'h0}, 0);
    vecs[2] = mk(32'h0000_1238, 0, 5, 2, 4,
                 {32'h0, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, '0,
                 32'h0000_1230, 8'd3, 128'h44444444_33333333_22222222_11111111, 0);
    vecs[3] = mk(32'h8000_0040, 0, 0, 0, 4, {32'h0, 32'h4, 32'h3, 32'h2, 32'h1},
                 {2'b00, 2'b00, 2'b00, 2'b10, 2'b00},
                 32'h8000_0040, 8'd3, 128'h00000004_00000003_00000002_00000001, 1);
    vecs[4] = mk(32'h0000_0010, 0, 0, 0, 2, {96'h0, 32'hDEAD0002, 32'hDEAD0001}, '0,
                 32'h0000_0010, 8'd3, {64'h0, 32'hDEAD0002, 32'hDEAD0001}, 1);
    vecs[5] = mk(32'h0000_0004, 1, 1, 1, 1, {128'h0, 32'hCAFEF00D},
                 {2'b00, 2'b00, 2'b00, 2'b00, 2'b11},
                 32'h0000_0004, 8'd0, {32'hCAFEF00D, 96'h0}, 1);
    vecs[6] = mk(32'h0000_010C, 0, 0, 1, 5, {32'h5, 32'h4, 32'h3, 32'h2, 32'h1}, '0,
                 32'h0000_0100, 8'd3, 128'h00000004_00000003_00000002_00000001, 1);
    vecs[7] = mk(32'h0000_3008, 1, 0, 0, 2, {96'h0, 32'hAAAA0002, 32'hAAAA0001}, '0,
                 32'h0000_3008, 8'd0, {32'hAAAA0002, 96'h0}, 1);

    repeat (3) @(negedge clk_g);
    checkOutput("reset_rd_rdy", rd_rdy, 1);
    checkOutput("reset_ar_r", {arvalid, rready}, 0);
    checkOutput("reset_ret", {ret_valid, ret_err}, 0);
    checkOutput("reset_ret_data", ret_data, 0);
    resetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_g);
      checkOutput("idle_no_req", {arvalid, rd_rdy}, 2'b01);
    end

    for (int i = 0; i < 8; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i]);
    end

    // Back-to-back: rd_req stays high, second request taken from IDLE only.
    $display("[TB] back-to-back");
    vb = mk(32'h0000_2004, 1, 0, 0, 1, {128'h0, 32'h0BADBEEF}, '0,
            32'h0000_2004, 8'd0, {32'h0BADBEEF, 96'h0}, 0);
    issue(vecs[0].addr, vecs[0].unc, 1'b1);
    rd_addr = vb.addr;
    rd_uncache = vb.unc;
    serve(vecs[0]);
    @(negedge clk_g);
    rd_req = 1'b0;
    serve(vb);

    // Synchronous reset in the middle of the data phase.
    $display("[TB] reset during R");
    issue(32'h4000_0000, 1'b0, 1'b0);
    arready = 1'b1;
    checkOutput("rst_arvalid", arvalid, 1);
    @(negedge clk_g);
    arready = 1'b0;
    rvalid = 1'b1; rdata = 32'h55; rlast = 1'b0;
    @(negedge clk_g);
    rdata = 32'h66;
    @(negedge clk_g);
    rvalid = 1'b0;
    resetn = 1'b0;
    @(negedge clk_g);
    checkOutput("rst_rready", rready, 0);
    checkOutput("rst_ret_valid", ret_valid, 0);
    checkOutput("rst_arvalid_low", arvalid, 0);
    checkOutput("rst_rd_rdy", rd_rdy, 1);
    checkOutput("rst_ret_data", ret_data, 0);
    resetn = 1'b1;
    @(negedge clk_g);
    checkOutput("rst_no_ret", ret_valid, 0);
    applyStimulus(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
